// File: rtl/weights_stream_reader.sv
// rtl/weights_stream_reader.sv - streams a contiguous run of weights ROM words through a 2-entry FIFO
module weights_stream_reader #(
  parameter int W_DATA = 3,
  parameter int W_ADDR = 12,
  parameter int W_CNT  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W_ADDR-1:0] base_addr,
  input  logic [W_CNT-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [W_ADDR-1:0] rom_addr,
  input  logic [W_DATA-1:0] rom_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [W_DATA-1:0] m_data,
  output logic              m_last
);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state;
  logic [W_ADDR-1:0] base_r;
  logic [W_CNT-1:0]  cnt_r;
  logic [W_CNT-1:0]  issued_cnt;
  logic [W_CNT-1:0]  beat_cnt;
  logic              inflight;
  logic [W_DATA-1:0] fifo_mem [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        fifo_cnt;
  logic              pop;
  logic              push;
  logic              last_hs;
  logic [2:0]        occ;

  assign pop     = m_valid && m_ready;
  assign push    = inflight;
  assign last_hs = pop && m_last;

  // Occupancy after this edge if a read were issued now; keeps FIFO + in-flight within 2.
  assign occ      = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign rom_en   = (state == FETCH) && (issued_cnt < cnt_r) && (occ < 3'd2);
  assign rom_addr = base_r + W_ADDR'(issued_cnt);

  assign busy    = (state == FETCH);
  assign m_valid = (fifo_cnt != 2'd0);
  assign m_data  = fifo_mem[rd_ptr];
  assign m_last  = m_valid && (beat_cnt == cnt_r - W_CNT'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      done        <= 1'b0;
      base_r      <= '0;
      cnt_r       <= '0;
      issued_cnt  <= '0;
      beat_cnt    <= '0;
      inflight    <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      done     <= 1'b0;
      inflight <= rom_en;
      if (rom_en)
        issued_cnt <= issued_cnt + W_CNT'(1);
      if (push) begin
        fifo_mem[wr_ptr] <= rom_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        beat_cnt <= beat_cnt + W_CNT'(1);
      end
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};

      case (state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              state      <= FETCH;
              base_r     <= base_addr;
              cnt_r      <= count;
              issued_cnt <= '0;
              beat_cnt   <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (last_hs) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
